// File: rtl/boot_memory_2port.sv
// Dual-port boot memory: clears itself after reset, takes a streamed boot image,
// then serves an instruction read port and a data read/write port.
module boot_memory_2port #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned CNT_W  = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              load_skip,
    output logic              load_ready,
    output logic [CNT_W-1:0]  load_count,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_data,
    input  logic              d_en,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ready,
    output logic              addr_err
);

    localparam int unsigned       PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LIMIT    = ADDR_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {StClear, StLoad, StRun} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    clr_ptr_q, clr_ptr_d;
    logic [PTR_W-1:0]    ld_ptr_q, ld_ptr_d;
    logic [CNT_W-1:0]    load_count_q, load_count_d;
    logic                addr_err_q, addr_err_d;
    logic [DATA_W-1:0]   i_data_q, i_data_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wr_en;
    logic [PTR_W-1:0]    wr_idx;
    logic [DATA_W-1:0]   wr_data;

    // Range checks use the full address so high addresses never alias.
    logic                i_in_range, d_in_range;
    logic [PTR_W-1:0]    i_idx, d_idx;

    assign i_in_range = i_addr < LIMIT;
    assign d_in_range = d_addr < LIMIT;
    assign i_idx      = i_addr[PTR_W-1:0];
    assign d_idx      = d_addr[PTR_W-1:0];

    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        ld_ptr_d     = ld_ptr_q;
        load_count_d = load_count_q;
        addr_err_d   = addr_err_q;
        i_data_d     = i_data_q;
        d_rdata_d    = d_rdata_q;
        wr_en        = 1'b0;
        wr_idx       = clr_ptr_q;
        wr_data      = '0;

        unique case (state_q)
            StClear: begin
                wr_en  = 1'b1;
                wr_idx = clr_ptr_q;
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = StLoad;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            StLoad: begin
                if (load_valid) begin
                    wr_en        = 1'b1;
                    wr_idx       = ld_ptr_q;
                    wr_data      = load_data;
                    load_count_d = load_count_q + 1'b1;
                    if (load_last || load_skip || ld_ptr_q == LAST_PTR) begin
                        state_d = StRun;
                    end else begin
                        ld_ptr_d = ld_ptr_q + 1'b1;
                    end
                end else if (load_skip) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (d_en && d_we) begin
                    if (d_in_range) begin
                        wr_en   = 1'b1;
                        wr_idx  = d_idx;
                        wr_data = d_wdata;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end else if (d_en) begin
                    if (d_in_range) begin
                        d_rdata_d = mem[d_idx];
                    end else begin
                        d_rdata_d  = '0;
                        addr_err_d = 1'b1;
                    end
                end
                if (i_en) begin
                    if (i_in_range) begin
                        // Write-first: a same-edge data write is forwarded to fetch.
                        i_data_d = (wr_en && wr_idx == i_idx) ? d_wdata : mem[i_idx];
                    end else begin
                        i_data_d   = '0;
                        addr_err_d = 1'b1;
                    end
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StClear;
            clr_ptr_q    <= '0;
            ld_ptr_q     <= '0;
            load_count_q <= '0;
            addr_err_q   <= 1'b0;
            i_data_q     <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            ld_ptr_q     <= ld_ptr_d;
            load_count_q <= load_count_d;
            addr_err_q   <= addr_err_d;
            i_data_q     <= i_data_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign ready      = (state_q == StRun);
    assign load_ready = (state_q == StLoad);
    assign load_count = load_count_q;
    assign addr_err   = addr_err_q;
    assign i_data     = i_data_q;
    assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_boot_memory_2port.sv
// Directed bench for boot_memory_2port: clear timing, boot load, both ports,
// collisions, out-of-range handling and reset during load.
module tb_boot_memory_2port;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned CNT_W  = 10;

    logic              clock = 1'b0;
    logic              reset;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_skip;
    logic              load_ready;
    logic [CNT_W-1:0]  load_count;
    logic              i_en;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_data;
    logic              d_en;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              ready;
    logic              addr_err;

    int n_vec = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q [$];

    boot_memory_2port #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_last (load_last),
        .load_skip (load_skip),
        .load_ready(load_ready),
        .load_count(load_count),
        .i_en      (i_en),
        .i_addr    (i_addr),
        .i_data    (i_data),
        .d_en      (d_en),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .ready     (ready),
        .addr_err  (addr_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        load_skip  = 1'b0;
        i_en       = 1'b0;
        i_addr     = '0;
        d_en       = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Bounded wait for the clear sequence; an overrun shows as a wrong length.
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (!load_ready && n < 2000) begin
            tick();
            n++;
        end
        check(tag, n, DEPTH);
    endtask

    task automatic skip_load();
        load_skip = 1'b1;
        tick();
        load_skip = 1'b0;
    endtask

    task automatic read_i(input string tag, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] exp);
        i_en   = 1'b1;
        i_addr = a;
        exp_q.push_back(exp);
        tick();
        i_en = 1'b0;
        check(tag, i_data, exp_q.pop_front());
    endtask

    task automatic read_d(input string tag, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] exp);
        d_en   = 1'b1;
        d_we   = 1'b0;
        d_addr = a;
        exp_q.push_back(exp);
        tick();
        d_en = 1'b0;
        check(tag, d_rdata, exp_q.pop_front());
    endtask

    task automatic write_d(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
        d_en    = 1'b1;
        d_we    = 1'b1;
        d_addr  = a;
        d_wdata = v;
        tick();
        d_en = 1'b0;
        d_we = 1'b0;
    endtask

    initial begin
        int accepted;
        logic rdy;
        logic [DATA_W-1:0] last_val;

        // Reset values and clear length.
        do_reset();
        check("rst_ready", ready, 0);
        check("rst_load_ready", load_ready, 0);
        check("rst_load_count", load_count, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_i_data", i_data, 0);
        check("rst_d_rdata", d_rdata, 0);
        wait_clear("clear_len_a");
        check("clear_ready_low", ready, 0);

        // Port requests before RUN are ignored.
        d_en = 1'b1; d_we = 1'b1; d_addr = 16'd300; d_wdata = 16'h5A5A;
        tick();
        d_we = 1'b0; d_addr = 16'hFFFF; i_en = 1'b1; i_addr = 16'hFFFF;
        tick();
        d_en = 1'b0; i_en = 1'b0;
        check("load_no_err", addr_err, 0);
        check("load_d_hold", d_rdata, 0);
        skip_load();
        check("skip_ready", ready, 1);
        check("skip_load_ready", load_ready, 0);
        check("skip_count", load_count, 0);
        read_d("d_rd_300_clear", 16'd300, 16'h0000);
        read_i("i_rd_300_clear", 16'd300, 16'h0000);

        // Three-word boot image.
        do_reset();
        wait_clear("clear_len_b");
        load_valid = 1'b1;
        load_data = 16'h0008; tick();
        load_data = 16'h0814; tick();
        check("load_mid_ready", ready, 0);
        load_data = 16'h8014; load_last = 1'b1; tick();
        load_valid = 1'b0; load_last = 1'b0;
        check("load3_ready", ready, 1);
        check("load3_load_ready", load_ready, 0);
        check("load3_count", load_count, 3);
        read_i("i_rd_1", 16'd1, 16'h0814);
        tick();
        check("i_hold", i_data, 16'h0814);

        // Write-first collision.
        i_en = 1'b1; i_addr = 16'd20;
        d_en = 1'b1; d_we = 1'b1; d_addr = 16'd20; d_wdata = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        tick();
        i_en = 1'b0; d_en = 1'b0; d_we = 1'b0;
        check("collide_i", i_data, exp_q.pop_front());
        check("write_no_rdata", d_rdata, 0);
        read_d("d_rd_20", 16'd20, 16'hBEEF);

        // Out of range.
        check("err_before", addr_err, 0);
        write_d(16'd512, 16'h1234);
        check("err_set", addr_err, 1);
        read_d("d_rd_0_noalias", 16'd0, 16'h0008);
        read_i("i_rd_ffff", 16'hFFFF, 16'h0000);
        read_d("d_rd_512", 16'd512, 16'h0000);
        tick();
        check("err_sticky", addr_err, 1);
        check("run_load_count", load_count, 3);

        // Overlong stream: the last in-range slot ends the load.
        do_reset();
        check("err_cleared", addr_err, 0);
        wait_clear("clear_len_c");
        accepted = 0;
        last_val = '0;
        for (int i = 0; i < 600; i++) begin
            load_valid = 1'b1;
            load_data  = 16'(16'h1000 + i);
            rdy = load_ready;
            tick();
            if (rdy) begin
                accepted++;
                last_val = 16'(16'h1000 + i);
            end
        end
        load_valid = 1'b0;
        check("stream_accepted", accepted, DEPTH);
        check("stream_load_ready", load_ready, 0);
        check("stream_count", load_count, DEPTH);
        check("stream_ready", ready, 1);
        read_i("i_rd_511", 16'd511, last_val);
        read_d("d_rd_510", 16'd510, 16'h11FE);

        // Reset in the middle of a load.
        do_reset();
        wait_clear("clear_len_d");
        load_valid = 1'b1;
        load_data = 16'hAAAA; tick();
        load_data = 16'h5555; tick();
        check("mid_count", load_count, 2);
        load_data = 16'h7777;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load_valid = 1'b0;
        check("mid_rst_count", load_count, 0);
        check("mid_rst_load_ready", load_ready, 0);
        wait_clear("clear_len_e");
        skip_load();
        read_i("i_rd_0_cleared", 16'd0, 16'h0000);
        read_d("d_rd_1_cleared", 16'd1, 16'h0000);
        read_d("d_rd_2_cleared", 16'd2, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
